// File: rtl/eth_pkg.sv
// Shared types and default constants for the Ethernet TX arbiter slice.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } eth_state_e;

    localparam int ETH_DATA_WIDTH = 64;
    localparam int ETH_MAX_BEATS  = 192;

endpackage

// File: rtl/eth_tx_arb_if.sv
// Bundled AXI-Stream slave channels, merged master stream and statistics of eth_tx_arb.
interface eth_tx_arb_if import eth_pkg::*; #(
    parameter int NUM_PORTS    = 2,
    parameter int C_DATA_WIDTH = ETH_DATA_WIDTH,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
);
    logic [NUM_PORTS-1:0]              s_axis_tvalid;
    logic [NUM_PORTS-1:0]              s_axis_tready;
    logic [NUM_PORTS-1:0]              s_axis_tlast;
    logic [NUM_PORTS-1:0]              s_axis_tuser;
    logic [NUM_PORTS*C_DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep;

    logic                              m_axis_tvalid;
    logic                              m_axis_tready;
    logic [C_DATA_WIDTH-1:0]           m_axis_tdata;
    logic [KEEP_WIDTH-1:0]             m_axis_tkeep;
    logic                              m_axis_tlast;
    logic                              m_axis_tuser;

    logic [$clog2(NUM_PORTS)-1:0]      grant;
    logic [NUM_PORTS*32-1:0]           pkt_cnt;
    logic [31:0]                       trunc_cnt;

    modport master (
        input  s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tdata, s_axis_tkeep,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
        output grant, pkt_cnt, trunc_cnt
    );

    modport slave (
        output s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tdata, s_axis_tkeep,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
        input  grant, pkt_cnt, trunc_cnt
    );

endinterface

// File: rtl/eth_rr_arb.sv
// Combinational round-robin pick: first requester strictly after last_grant, wrapping.
module eth_rr_arb #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     next_grant,
    output logic                 any_req
);

    int unsigned idx;

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        next_grant = '0;
        idx        = 0;
        any_req    = |req;
        for (int unsigned i = NUM_PORTS; i >= 1; i--) begin
            idx = (32'(last_grant) + i) % NUM_PORTS;
            if (req[IDX_W'(idx)]) begin
                next_grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-level round-robin merge of NUM_PORTS AXI-Stream channels onto one MAC TX stream.
// Optional statistics counters are built when ETH_TX_ARB_STATS_EN is defined.
module eth_tx_arb import eth_pkg::*; #(
    parameter int NUM_PORTS    = 2,
    parameter int C_DATA_WIDTH = ETH_DATA_WIDTH,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int MAX_BEATS    = ETH_MAX_BEATS
) (
    input  logic         clk156,
    input  logic         eth_rst_n,
    eth_tx_arb_if.master bus
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int BCW   = $clog2(MAX_BEATS);

    eth_state_e              state_q, state_d;
    logic [IDX_W-1:0]        grant_q, last_q, rr_next;
    logic                    rr_any;
    logic [BCW-1:0]          beat_q;
    logic                    sel_valid, sel_last, sel_user;
    logic [C_DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic                    hs, trunc_hit;

    eth_rr_arb #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr (
        .req        (bus.s_axis_tvalid),
        .last_grant (last_q),
        .next_grant (rr_next),
        .any_req    (rr_any)
    );

    assign sel_valid = bus.s_axis_tvalid[grant_q];
    assign sel_last  = bus.s_axis_tlast[grant_q];
    assign sel_user  = bus.s_axis_tuser[grant_q];
    assign sel_data  = bus.s_axis_tdata[int'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign sel_keep  = bus.s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
    assign hs        = (state_q == XFER) && sel_valid && bus.m_axis_tready;
    assign trunc_hit = (beat_q == BCW'(MAX_BEATS - 1)) && !sel_last;
    assign bus.grant = grant_q;

    // last_q resets to the top port so port 0 wins the first arbitration.
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && rr_any) begin
                grant_q <= rr_next;
                last_q  <= rr_next;
                beat_q  <= '0;
            end else if (hs) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rr_any) state_d = XFER;
            XFER: begin
                if (hs) begin
                    if (sel_last)       state_d = IDLE;
                    else if (trunc_hit) state_d = DRAIN;
                end
            end
            DRAIN:   if (sel_valid && sel_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_axis_tready = '0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tkeep  = '0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tuser  = 1'b0;
        case (state_q)
            XFER: begin
                bus.m_axis_tvalid          = sel_valid;
                bus.m_axis_tdata           = sel_data;
                bus.m_axis_tkeep           = sel_keep;
                bus.m_axis_tlast           = sel_last | trunc_hit;
                bus.m_axis_tuser           = sel_user | trunc_hit;
                bus.s_axis_tready[grant_q] = bus.m_axis_tready;
            end
            DRAIN:   bus.s_axis_tready[grant_q] = 1'b1;
            default: ;
        endcase
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] pkt_q [NUM_PORTS];
    logic [31:0] trunc_q;

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) pkt_q[i] <= '0;
            trunc_q <= '0;
        end else begin
            if (hs && (sel_last || trunc_hit)) pkt_q[grant_q] <= pkt_q[grant_q] + 32'd1;
            if (hs && trunc_hit)               trunc_q        <= trunc_q + 32'd1;
        end
    end

    always_comb begin
        bus.pkt_cnt = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) bus.pkt_cnt[i*32 +: 32] = pkt_q[i];
    end
    assign bus.trunc_cnt = trunc_q;
`else
    assign bus.pkt_cnt   = '0;
    assign bus.trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Self-checking bench for eth_tx_arb: packet-level round-robin reference model, randomized payloads.
module tb_eth_tx_arb;

    localparam int NP = 3;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int MB = 4;
`ifdef ETH_TX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct {
        beat_t b;
        int    port;
        int    cyc;
    } obs_t;

    logic clk156    = 1'b0;
    logic eth_rst_n = 1'b0;
    always #3 clk156 = ~clk156;

    eth_tx_arb_if #(.NUM_PORTS(NP), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

    eth_tx_arb #(.NUM_PORTS(NP), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MB)) dut (
        .clk156    (clk156),
        .eth_rst_n (eth_rst_n),
        .bus       (bus)
    );

    beat_t src_q [NP][$];
    beat_t mq    [NP][$];
    beat_t exp_b [$];
    int    exp_p [$];
    obs_t  obs   [$];
    int    m_ptr;
    int    m_trunc;
    int    m_pkt [NP];
    int    checks = 0;
    int    errors = 0;

    task automatic clear_all();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mq[p].delete();
        end
        exp_b.delete();
        exp_p.delete();
        obs.delete();
    endtask

    task automatic add_pkt(input int p, input int len);
        beat_t b;
        for (int k = 1; k <= len; k++) begin
            b.data = {$urandom, $urandom};
            b.keep = (k == len) ? KW'($urandom_range(1, 255)) : '1;
            b.last = (k == len);
            b.user = ($urandom_range(0, 7) == 0);
            src_q[p].push_back(b);
            mq[p].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                bus.s_axis_tvalid[p]           = 1'b1;
                bus.s_axis_tdata[p*DW +: DW]   = src_q[p][0].data;
                bus.s_axis_tkeep[p*KW +: KW]   = src_q[p][0].keep;
                bus.s_axis_tlast[p]            = src_q[p][0].last;
                bus.s_axis_tuser[p]            = src_q[p][0].user;
            end else begin
                bus.s_axis_tvalid[p]           = 1'b0;
                bus.s_axis_tdata[p*DW +: DW]   = '0;
                bus.s_axis_tkeep[p*KW +: KW]   = '0;
                bus.s_axis_tlast[p]            = 1'b0;
                bus.s_axis_tuser[p]            = 1'b0;
            end
        end
    endtask

    // Reference: whole packets in round-robin order over ports holding data,
    // each cut to MB beats (forced tlast/tuser) with the remainder discarded.
    task automatic model_run();
        beat_t b;
        int    p, n;
        bit    busy;
        forever begin
            busy = 1'b0;
            for (int q = 0; q < NP; q++) if (mq[q].size() > 0) busy = 1'b1;
            if (!busy) break;
            p = m_ptr;
            for (int s = 0; s < NP; s++) begin
                p = (p + 1) % NP;
                if (mq[p].size() > 0) break;
            end
            m_ptr = p;
            n     = 0;
            forever begin
                b = mq[p].pop_front();
                n++;
                if (b.last) begin
                    exp_b.push_back(b); exp_p.push_back(p); m_pkt[p]++;
                    break;
                end
                if (n == MB) begin
                    b.last = 1'b1; b.user = 1'b1;
                    exp_b.push_back(b); exp_p.push_back(p); m_pkt[p]++; m_trunc++;
                    do b = mq[p].pop_front(); while (!b.last);
                    break;
                end
                exp_b.push_back(b); exp_p.push_back(p);
            end
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1 repeating, 2: random ~70%.
    task automatic run(input int mode, input int stop_after, input int budget, output bit done);
        logic [3:0] pat;
        bit         acc [NP];
        bit         empty;
        obs_t       o;
        pat  = 4'b1001;
        done = 1'b0;
        drive_inputs();
        bus.m_axis_tready = (mode == 1) ? pat[0] : 1'b1;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk156);
            for (int p = 0; p < NP; p++) acc[p] = bus.s_axis_tvalid[p] && bus.s_axis_tready[p];
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                o.b    = '{data: bus.m_axis_tdata, keep: bus.m_axis_tkeep,
                           last: bus.m_axis_tlast, user: bus.m_axis_tuser};
                o.port = int'(bus.grant);
                o.cyc  = t;
                obs.push_back(o);
            end
            if (stop_after > 0 && obs.size() >= stop_after) begin
                done = 1'b1;
                return;
            end
            @(posedge clk156);
            #1;
            for (int p = 0; p < NP; p++) if (acc[p]) void'(src_q[p].pop_front());
            drive_inputs();
            empty = 1'b1;
            for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) empty = 1'b0;
            if (empty) begin
                done = 1'b1;
                bus.m_axis_tready = 1'b1;
                return;
            end
            case (mode)
                1:       bus.m_axis_tready = pat[(t + 1) % 4];
                2:       bus.m_axis_tready = ($urandom_range(0, 9) < 7);
                default: bus.m_axis_tready = 1'b1;
            endcase
        end
    endtask

    task automatic apply_reset();
        eth_rst_n = 1'b0;
        clear_all();
        drive_inputs();
        bus.m_axis_tready = 1'b1;
        m_ptr   = NP - 1;
        m_trunc = 0;
        for (int p = 0; p < NP; p++) m_pkt[p] = 0;
        repeat (2) @(posedge clk156);
        @(negedge clk156);
        eth_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        add_pkt(0, 3);
        drive_inputs();
        bus.m_axis_tready = 1'b1;
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", bus.m_axis_tvalid); end
        checks++; if (bus.s_axis_tready !== '0) begin errors++; $display("FAIL rst_s_tready got %b exp 0", bus.s_axis_tready); end
        checks++; if (bus.grant !== '0) begin errors++; $display("FAIL rst_grant got %0d exp 0", bus.grant); end
        checks++; if (bus.m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h exp 0", bus.m_axis_tdata); end
        checks++; if (bus.pkt_cnt !== '0 || bus.trunc_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0", bus.pkt_cnt, bus.trunc_cnt); end
        apply_reset();
    endtask

    task automatic test_basic();
        bit done;
        apply_reset();
        add_pkt(0, 3);
        model_run();
        run(0, 0, 50, done);
        checks++; if (!done) begin errors++; $display("FAIL basic_timeout got 0 exp 1"); end
        checks++; if (obs.size() != exp_b.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", obs.size(), exp_b.size()); end
        for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
            checks++;
            if (obs[k].b !== exp_b[k] || obs[k].port != exp_p[k]) begin
                errors++; $display("FAIL basic_beat%0d got %h/p%0d exp %h/p%0d", k, obs[k].b, obs[k].port, exp_b[k], exp_p[k]);
            end
        end
        checks++;
        if (bus.pkt_cnt[31:0] !== 32'(STATS ? m_pkt[0] : 0)) begin
            errors++; $display("FAIL basic_pkt_cnt0 got %0d exp %0d", bus.pkt_cnt[31:0], STATS ? m_pkt[0] : 0);
        end
    endtask

    task automatic test_alternate();
        bit done;
        int gap;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            add_pkt(0, 2);
            add_pkt(1, 2);
        end
        model_run();
        run(0, 0, 100, done);
        checks++; if (!done) begin errors++; $display("FAIL alt_timeout got 0 exp 1"); end
        checks++; if (obs.size() != exp_b.size()) begin errors++; $display("FAIL alt_count got %0d exp %0d", obs.size(), exp_b.size()); end
        for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
            checks++;
            if (obs[k].b !== exp_b[k] || obs[k].port != exp_p[k]) begin
                errors++; $display("FAIL alt_beat%0d got %h/p%0d exp %h/p%0d", k, obs[k].b, obs[k].port, exp_b[k], exp_p[k]);
            end
        end
        // One idle cycle separates packets; beats within a packet are back to back.
        for (int k = 1; k < obs.size(); k++) begin
            gap = obs[k-1].b.last ? 2 : 1;
            checks++;
            if (obs[k].cyc - obs[k-1].cyc != gap) begin
                errors++; $display("FAIL alt_gap%0d got %0d exp %0d", k, obs[k].cyc - obs[k-1].cyc, gap);
            end
        end
    endtask

    task automatic test_truncate();
        bit done;
        obs.delete(); exp_b.delete(); exp_p.delete();
        add_pkt(1, 6);
        add_pkt(1, MB);
        model_run();
        run(0, 0, 100, done);
        checks++; if (!done) begin errors++; $display("FAIL trunc_timeout got 0 exp 1"); end
        checks++; if (obs.size() != exp_b.size()) begin errors++; $display("FAIL trunc_count got %0d exp %0d", obs.size(), exp_b.size()); end
        for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
            checks++;
            if (obs[k].b !== exp_b[k] || obs[k].port != exp_p[k]) begin
                errors++; $display("FAIL trunc_beat%0d got %h/p%0d exp %h/p%0d", k, obs[k].b, obs[k].port, exp_b[k], exp_p[k]);
            end
        end
        checks++;
        if (bus.trunc_cnt !== 32'(STATS ? m_trunc : 0)) begin
            errors++; $display("FAIL trunc_cnt got %0d exp %0d", bus.trunc_cnt, STATS ? m_trunc : 0);
        end
    endtask

    task automatic test_backpressure();
        bit done;
        obs.delete(); exp_b.delete(); exp_p.delete();
        add_pkt(2, 4);
        add_pkt(0, 5);
        add_pkt(1, 3);
        model_run();
        run(1, 0, 200, done);
        checks++; if (!done) begin errors++; $display("FAIL bp_timeout got 0 exp 1"); end
        checks++; if (obs.size() != exp_b.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", obs.size(), exp_b.size()); end
        for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
            checks++;
            if (obs[k].b !== exp_b[k] || obs[k].port != exp_p[k]) begin
                errors++; $display("FAIL bp_beat%0d got %h/p%0d exp %h/p%0d", k, obs[k].b, obs[k].port, exp_b[k], exp_p[k]);
            end
        end
    endtask

    task automatic test_reset_cut();
        bit done;
        apply_reset();
        add_pkt(0, 1);
        model_run();
        run(0, 0, 50, done);
        checks++; if (!done) begin errors++; $display("FAIL cut_pre_timeout got 0 exp 1"); end
        obs.delete();
        add_pkt(1, 5);
        add_pkt(0, 2);
        run(0, 2, 50, done);
        checks++; if (!done || obs[0].port != 1) begin errors++; $display("FAIL cut_owner got %0d exp 1", done ? obs[0].port : -1); end
        #1 eth_rst_n = 1'b0;
        #1;
        checks++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL cut_mvalid got %b%b exp 00", bus.m_axis_tvalid, bus.m_axis_tlast); end
        checks++; if (bus.m_axis_tdata !== '0 || bus.m_axis_tkeep !== '0) begin errors++; $display("FAIL cut_mdata got %h exp 0", bus.m_axis_tdata); end
        checks++; if (bus.s_axis_tready !== '0) begin errors++; $display("FAIL cut_s_tready got %b exp 0", bus.s_axis_tready); end
        checks++; if (bus.grant !== '0) begin errors++; $display("FAIL cut_grant got %0d exp 0", bus.grant); end
        checks++; if (bus.pkt_cnt !== '0 || bus.trunc_cnt !== '0) begin errors++; $display("FAIL cut_cnt got %h/%h exp 0", bus.pkt_cnt, bus.trunc_cnt); end
        apply_reset();
        add_pkt(1, 2);
        add_pkt(0, 2);
        model_run();
        run(0, 0, 100, done);
        checks++; if (!done || obs.size() == 0 || obs[0].port != 0) begin errors++; $display("FAIL cut_first_grant got %0d exp 0", obs.size() > 0 ? obs[0].port : -1); end
        checks++; if (obs.size() != exp_b.size()) begin errors++; $display("FAIL cut_count got %0d exp %0d", obs.size(), exp_b.size()); end
        for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
            checks++;
            if (obs[k].b !== exp_b[k] || obs[k].port != exp_p[k]) begin
                errors++; $display("FAIL cut_beat%0d got %h/p%0d exp %h/p%0d", k, obs[k].b, obs[k].port, exp_b[k], exp_p[k]);
            end
        end
    endtask

    task automatic test_random();
        bit done;
        apply_reset();
        for (int i = 0; i < 14; i++) add_pkt($urandom_range(0, NP - 1), $urandom_range(1, 6));
        model_run();
        run(2, 0, 3000, done);
        checks++; if (!done) begin errors++; $display("FAIL rnd_timeout got 0 exp 1"); end
        checks++; if (obs.size() != exp_b.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", obs.size(), exp_b.size()); end
        for (int k = 0; k < obs.size() && k < exp_b.size(); k++) begin
            checks++;
            if (obs[k].b !== exp_b[k] || obs[k].port != exp_p[k]) begin
                errors++; $display("FAIL rnd_beat%0d got %h/p%0d exp %h/p%0d", k, obs[k].b, obs[k].port, exp_b[k], exp_p[k]);
            end
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (bus.pkt_cnt[p*32 +: 32] !== 32'(STATS ? m_pkt[p] : 0)) begin
                errors++; $display("FAIL rnd_pkt_cnt%0d got %0d exp %0d", p, bus.pkt_cnt[p*32 +: 32], STATS ? m_pkt[p] : 0);
            end
        end
        checks++;
        if (bus.trunc_cnt !== 32'(STATS ? m_trunc : 0)) begin
            errors++; $display("FAIL rnd_trunc_cnt got %0d exp %0d", bus.trunc_cnt, STATS ? m_trunc : 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_truncate();
        test_backpressure();
        test_reset_cut();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, giving the number of AXI-Stream slave channels (legal range 2..8).
REQ-002 The block SHALL have parameter C_DATA_WIDTH, default 64, giving the tdata width in bits (64 or 128).
REQ-003 The block SHALL have parameter KEEP_WIDTH, default C_DATA_WIDTH/8, giving the tkeep width (one bit per byte).
REQ-004 The block SHALL have parameter MAX_BEATS, default 192, giving the maximum number of beats per packet (range 2..4096).
REQ-005 The block SHALL have port clk156, input, 1 bit: 156.25 MHz MAC clock; sole clock.
REQ-006 The block SHALL have port eth_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports s_axis_tvalid/tready/tlast/tuser, in/out/in/in, NUM_PORTS bits each: per-port handshake, end-of-packet and error bits.
REQ-008 The block SHALL have ports s_axis_tdata, input, NUM_PORTS*C_DATA_WIDTH, and s_axis_tkeep, input, NUM_PORTS*KEEP_WIDTH: port i is held in slice i.
REQ-009 The block SHALL have ports m_axis_tvalid, m_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast and m_axis_tuser (out, in, out, out, out, out): the merged stream toward the MAC TX.
REQ-010 The block SHALL have port grant, output, $clog2(NUM_PORTS) bits: the index of the currently owning port.
REQ-011 The block SHALL have ports pkt_cnt, output, NUM_PORTS*32, and trunc_cnt, output, 32 bits: statistics (see Configuration).

Function
REQ-012 The block SHALL use a three-state FSM: IDLE, XFER, DRAIN.
REQ-013 In IDLE, when any s_axis_tvalid is high, the block SHALL register grant as the first requester after the last granted port in round-robin order and enter XFER on the next edge.
REQ-014 In IDLE, the block SHALL hold all s_axis_tready and m_axis_tvalid low.
REQ-015 In XFER, the block SHALL combinationally route m_axis_* from s_axis_*[grant], drive s_axis_tready[grant] from m_axis_tready, and hold all other s_axis_tready low.
REQ-016 Data latency SHALL be zero cycles once in XFER; request-to-first-beat latency SHALL be one cycle.
REQ-017 The block SHALL count accepted beats with a beat counter that clears on entry to XFER.
REQ-018 A handshake with s_axis_tlast high SHALL return the FSM to IDLE, giving one idle cycle between packets.
REQ-019 Ownership SHALL never change mid-packet, regardless of other ports' tvalid.
REQ-020 When the beat counter equals MAX_BEATS-1 and the current beat lacks tlast, the block SHALL output that beat with m_axis_tlast=1 and m_axis_tuser=1, then enter DRAIN.
REQ-021 In DRAIN, the block SHALL hold s_axis_tready[grant] high and m_axis_tvalid low, discarding beats until an input tlast is accepted, then enter IDLE.
REQ-022 A beat at MAX_BEATS-1 that carries tlast SHALL be passed unmodified, with no truncation.
REQ-023 Input tuser SHALL pass through to m_axis_tuser; the truncation case ORs in 1.
REQ-024 When m_axis_tready is low, all outputs SHALL hold and the beat counter SHALL not advance.

Reset
REQ-025 Reset assertion SHALL act asynchronously at any time, including mid-packet; deassertion is synchronised externally.
REQ-026 During reset, the FSM SHALL be IDLE; grant, m_axis_*, s_axis_tready and the counters SHALL be 0.
REQ-027 During reset, the round-robin pointer SHALL be set so that port 0 wins first.
REQ-028 A packet cut by reset SHALL NOT be resumed.

Configuration
REQ-029 With macro ETH_TX_ARB_STATS_EN defined, pkt_cnt[i] SHALL increment on each output tlast handshake from port i.
REQ-030 With ETH_TX_ARB_STATS_EN defined, trunc_cnt SHALL increment on each truncation; both counters SHALL wrap at 2^32.
REQ-031 Without ETH_TX_ARB_STATS_EN, pkt_cnt and trunc_cnt SHALL be tied to 0 and no counter registers SHALL be synthesised.

Structure
REQ-032 Package eth_pkg SHALL hold the FSM state typedef (IDLE/XFER/DRAIN) and the default constants for C_DATA_WIDTH and MAX_BEATS.
REQ-033 Round-robin selection SHALL be a sub-module eth_rr_arb: request vector and last grant in, next grant index and any-request out; purely combinational.

Verification
REQ-034 Bench scenario: reset, then port 0 sends a 3-beat packet with m_axis_tready=1 -> grant=0, output beats 1..3 with tlast on beat 3, pkt_cnt[0]=1.
REQ-035 Bench scenario: ports 0 and 1 continuously valid with 2-beat packets -> output alternates 0,1,0,1 with one idle cycle between packets.
REQ-036 Bench scenario: MAX_BEATS=4, port 1 sends 6 beats without early tlast -> output 4 beats, beat 4 has tlast=1 and tuser=1; beats 5-6 are consumed and not forwarded; trunc_cnt=1.
REQ-037 Bench scenario: m_axis_tready toggled 1,0,0,1 during a 4-beat packet -> output beats arrive in order with none lost or duplicated, and the beat counter advances only on handshake.
REQ-038 Bench scenario: eth_rst_n asserted on beat 2 of 5 -> same-cycle outputs are 0 and the FSM is IDLE; after release, port 0 is granted first.
REQ-039 Bench scenario: build without ETH_TX_ARB_STATS_EN -> after 10 packets, pkt_cnt=0 and trunc_cnt=0.
